pip_processor_v2: RTL and testbench

PIP_PROCESSOR_V2 -- requirements
Module: pip_processor_v2

---
 rtl/pip_processor_v2.sv | 250 +++++++++++++++++++++++++
 tb/tb_pip_processor_v2.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pip_processor_v2.sv
// Three-stage D/X/W integer pipeline with full X->D forwarding,
// hold freeze, sticky illegal-opcode flag and retired counter.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   instruction[31:0]       {op, rd, rs1, rs2, imm16}
//   instr_valid/instr_ready offer / accept handshake
//   hold                    freezes the whole pipeline
//   result, result_rd       write-back value and destination
//   result_valid            one pulse per retired writing instr
//   ovf                     signed overflow of ADD/SUB/ADDI
//   illegal                 sticky: undefined opcode accepted
//   retired_cnt             count of result_valid pulses
module pip_processor_v2 #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              hold,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        result_rd,
  output logic              result_valid,
  output logic              ovf,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;

  localparam int MSB = DATA_W - 1;

  // Register numbers beyond the implemented file alias R0.
  function automatic logic [3:0] norm(input logic [3:0] r);
    return (int'(r) < NREG) ? r : 4'd0;
  endfunction

  // ---------------- accept / decode ----------------
  logic       acc;
  logic [3:0] in_op;
  logic [3:0] in_rd;
  logic       in_def;
  logic       in_wr;

  assign instr_ready = ~hold;
  assign acc         = instr_valid & ~hold;
  assign in_op       = instruction[31:28];
  assign in_rd       = norm(instruction[27:24]);
  assign in_def      = ~in_op[3];
  // Only writing instructions travel down the pipe;
  // NOPs, undefined ops and rd=R0 become bubbles.
  assign in_wr       = in_def && (in_op != OP_NOP)
                       && (in_rd != 4'd0);

  // ---------------- D stage ----------------
  logic        d_vld_q;
  logic [3:0]  d_op_q;
  logic [3:0]  d_rd_q;
  logic [3:0]  d_rs1_q;
  logic [3:0]  d_rs2_q;
  logic [15:0] d_imm_q;
  logic        ill_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_vld_q <= 1'b0;
      d_op_q  <= '0;
      d_rd_q  <= '0;
      d_rs1_q <= '0;
      d_rs2_q <= '0;
      d_imm_q <= '0;
      ill_q   <= 1'b0;
    end else if (!hold) begin
      d_vld_q <= acc & in_wr;
      if (acc) begin
        d_op_q  <= in_op;
        d_rd_q  <= in_rd;
        d_rs1_q <= norm(instruction[23:20]);
        d_rs2_q <= norm(instruction[19:16]);
        d_imm_q <= instruction[15:0];
      end
      if (acc && !in_def) begin
        ill_q <= 1'b1;
      end
    end
  end

  // ---------------- X stage regs ----------------
  logic              x_vld_q;
  logic [3:0]        x_rd_q;
  logic [DATA_W-1:0] x_res_q;
  logic              x_ovf_q;

  // ---------------- register file ----------------
  logic [DATA_W-1:0] rf_q [NREG];

  // ---------------- operand read ----------------
  // The instruction one ahead sits in X and has not
  // written yet, so its result is forwarded. Anything
  // older has already been written to the file.
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  always_comb begin
    opa = '0;
    opb = '0;
    if (d_rs1_q != 4'd0) begin
      if (x_vld_q && x_rd_q == d_rs1_q) begin
        opa = x_res_q;
      end else begin
        opa = rf_q[d_rs1_q];
      end
    end
    if (d_rs2_q != 4'd0) begin
      if (x_vld_q && x_rd_q == d_rs2_q) begin
        opb = x_res_q;
      end else begin
        opb = rf_q[d_rs2_q];
      end
    end
  end

  // ---------------- ALU ----------------
  logic [DATA_W-1:0] imm_x;
  logic [DATA_W-1:0] addb;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] dif;
  logic              sum_ovf;
  logic              dif_ovf;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  logic is_add;
  logic is_sub;
  logic is_mov;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_addi;

  assign imm_x = DATA_W'($signed(d_imm_q));
  assign addb  = (d_op_q == OP_ADDI) ? imm_x : opb;
  assign sum   = opa + addb;
  assign dif   = opa - opb;

  assign sum_ovf = (opa[MSB] == addb[MSB])
                   && (sum[MSB] != opa[MSB]);
  assign dif_ovf = (opa[MSB] != opb[MSB])
                   && (dif[MSB] != opa[MSB]);

  assign is_add  = (d_op_q == OP_ADD);
  assign is_sub  = (d_op_q == OP_SUB);
  assign is_mov  = (d_op_q == OP_MOV);
  assign is_and  = (d_op_q == OP_AND);
  assign is_or   = (d_op_q == OP_OR);
  assign is_xor  = (d_op_q == OP_XOR);
  assign is_addi = (d_op_q == OP_ADDI);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (1'b1)
      is_add, is_addi: begin
        alu_res = sum;
        alu_ovf = sum_ovf;
      end
      is_sub: begin
        alu_res = dif;
        alu_ovf = dif_ovf;
      end
      is_mov: alu_res = opa;
      is_and: alu_res = opa & opb;
      is_or:  alu_res = opa | opb;
      is_xor: alu_res = opa ^ opb;
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_vld_q <= 1'b0;
      x_rd_q  <= '0;
      x_res_q <= '0;
      x_ovf_q <= 1'b0;
    end else if (!hold) begin
      x_vld_q <= d_vld_q;
      if (d_vld_q) begin
        x_rd_q  <= d_rd_q;
        x_res_q <= alu_res;
        x_ovf_q <= alu_ovf;
      end
    end
  end

  // ---------------- W stage ----------------
  logic [DATA_W-1:0] res_q;
  logic [3:0]        rd_q;
  logic              rv_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      res_q <= '0;
      rd_q  <= '0;
      rv_q  <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (!hold) begin
      rv_q  <= x_vld_q;
      ovf_q <= x_vld_q & x_ovf_q;
      if (x_vld_q) begin
        rf_q[x_rd_q] <= x_res_q;
        res_q        <= x_res_q;
        rd_q         <= x_rd_q;
        cnt_q        <= cnt_d;
      end
    end
  end

  // A pulse caught under hold stays pending in rv_q
  // and shows once after release.
  assign result       = res_q;
  assign result_rd    = rd_q;
  assign result_valid = rv_q & ~hold;
  assign ovf          = ovf_q;
  assign illegal      = ill_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_pip_processor_v2.sv
// Directed bench for pip_processor_v2: a 32-bit and a
// 16-bit instance share one instruction stream.
module tb_pip_processor_v2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        hold;

  logic        rdy32, rv32, ovf32, ill32;
  logic [31:0] res32;
  logic [3:0]  rd32;
  logic [15:0] cnt32;

  logic        rdy16, rv16, ovf16, ill16;
  logic [15:0] res16;
  logic [3:0]  rd16;
  logic [15:0] cnt16;

  always #5 clk = ~clk;

  pip_processor_v2 u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(rdy32),
    .hold(hold), .result(res32), .result_rd(rd32),
    .result_valid(rv32), .ovf(ovf32),
    .illegal(ill32), .retired_cnt(cnt32)
  );

  pip_processor_v2 #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n),
    .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(rdy16),
    .hold(hold), .result(res16), .result_rd(rd16),
    .result_valid(rv16), .ovf(ovf16),
    .illegal(ill16), .retired_cnt(cnt16)
  );

  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic [3:0]  rd;
    logic [31:0] r32;
    logic [15:0] r16;
    logic        o32;
    logic        o16;
  } vec_t;

  vec_t tbl [24];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(
    input logic [3:0] op, input logic [3:0] rd,
    input logic [3:0] rs1, input logic [3:0] rs2,
    input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] i, input logic v,
    input logic [3:0] rd, input logic [31:0] r32,
    input logic [15:0] r16, input logic o32,
    input logic o16);
    vec_t t;
    t.ins = i; t.v = v; t.rd = rd;
    t.r32 = r32; t.r16 = r16;
    t.o32 = o32; t.o16 = o16;
    return t;
  endfunction

  // Streams tbl[lo..hi] back to back; vector j is
  // visible after the edge two after its accept.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi + 2; i++) begin
      if (i <= hi) begin
        instruction = tbl[i].ins;
        instr_valid = 1'b1;
      end else begin
        instruction = '0;
        instr_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i - 2 >= lo) begin
        int j;
        j = i - 2;
        if (tbl[j].v) exp_cnt++;
        chk($sformatf("v32[%0d]", j), rv32, tbl[j].v);
        chk($sformatf("v16[%0d]", j), rv16, tbl[j].v);
        if (tbl[j].v) begin
          chk($sformatf("res32[%0d]", j), res32, tbl[j].r32);
          chk($sformatf("res16[%0d]", j), res16, tbl[j].r16);
          chk($sformatf("rd[%0d]", j), rd32, tbl[j].rd);
          chk($sformatf("ovf32[%0d]", j), ovf32, tbl[j].o32);
          chk($sformatf("ovf16[%0d]", j), ovf16, tbl[j].o16);
        end
        chk($sformatf("cnt32[%0d]", j), cnt32, exp_cnt);
        chk($sformatf("cnt16[%0d]", j), cnt16, exp_cnt);
      end
    end
  endtask

  logic [35:0] got [$];
  logic [1:0]  rv_exp [4];

  initial begin
    // back-to-back dependency chains
    tbl[0]  = mk(ins(7,2,0,0,16'd10), 1, 2, 10, 10, 0, 0);
    tbl[1]  = mk(ins(7,3,0,0,16'd5),  1, 3, 5, 5, 0, 0);
    tbl[2]  = mk(ins(1,1,2,3,0),      1, 1, 15, 15, 0, 0);
    tbl[3]  = mk(ins(7,5,0,0,16'd20), 1, 5, 20, 20, 0, 0);
    tbl[4]  = mk(ins(7,6,0,0,16'd4),  1, 6, 4, 4, 0, 0);
    tbl[5]  = mk(ins(2,4,5,6,0),      1, 4, 16, 16, 0, 0);
    tbl[6]  = mk(ins(7,8,0,0,16'd42), 1, 8, 42, 42, 0, 0);
    tbl[7]  = mk(ins(3,7,8,0,0),      1, 7, 42, 42, 0, 0);
    tbl[8]  = mk(ins(4,11,5,6,0),     1, 11, 4, 4, 0, 0);
    tbl[9]  = mk(ins(5,12,5,6,0),     1, 12, 20, 20, 0, 0);
    tbl[10] = mk(ins(6,13,5,6,0),     1, 13, 16, 16, 0, 0);
    tbl[11] = mk(ins(0,9,5,6,0),      0, 0, 0, 0, 0, 0);
    tbl[12] = mk(ins(1,0,2,3,0),      0, 0, 0, 0, 0, 0);
    tbl[13] = mk(ins(3,14,0,0,0),     1, 14, 0, 0, 0, 0);
    // width wrap and signed overflow
    tbl[14] = mk(ins(7,1,0,0,16'hFFFF), 1, 1,
                 32'hFFFF_FFFF, 16'hFFFF, 0, 0);
    tbl[15] = mk(ins(1,9,1,1,0), 1, 9,
                 32'hFFFF_FFFE, 16'hFFFE, 0, 0);
    tbl[16] = mk(ins(7,10,0,0,16'h7FFF), 1, 10,
                 32'h7FFF, 16'h7FFF, 0, 0);
    tbl[17] = mk(ins(1,10,10,10,0), 1, 10,
                 32'hFFFE, 16'hFFFE, 0, 1);
    tbl[18] = mk(ins(7,15,0,0,16'h8000), 1, 15,
                 32'hFFFF_8000, 16'h8000, 0, 0);
    tbl[19] = mk(ins(2,15,15,3,0), 1, 15,
                 32'hFFFF_7FFB, 16'h7FFB, 0, 1);
    tbl[20] = mk(ins(7,11,5,0,16'hFFF0), 1, 11, 4, 4, 0, 0);
    // R0 target, undefined opcode
    tbl[21] = mk(ins(7,0,0,0,16'd7),  0, 0, 0, 0, 0, 0);
    tbl[22] = mk(ins(9,2,1,1,16'd3),  0, 0, 0, 0, 0, 0);
    tbl[23] = mk(ins(3,13,0,0,0),     1, 13, 0, 0, 0, 0);

    reset_n     = 1'b0;
    hold        = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    #3;
    chk("rst_result", res32, 0);
    chk("rst_rd", rd32, 0);
    chk("rst_valid", rv32, 0);
    chk("rst_ovf", ovf32, 0);
    chk("rst_illegal", ill32, 0);
    chk("rst_cnt", cnt32, 0);
    chk("rst_ready", rdy32, 1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    run(0, 20);
    chk("illegal_pre", ill32, 0);
    run(21, 23);
    chk("illegal32", ill32, 1);
    chk("illegal16", ill16, 1);

    // hold for 3 cycles after the second accept
    instr_valid = 1'b1;
    instruction = ins(7,1,0,0,16'd100);
    @(posedge clk); #1;
    instruction = ins(7,2,0,0,16'd101);
    @(posedge clk); #1;
    hold = 1'b1;
    instruction = ins(7,3,0,0,16'd102);
    #1;
    chk("hold_ready0", rdy32, 0);
    chk("hold_valid0", rv32, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_ready%0d", c + 1), rdy32, 0);
      chk($sformatf("hold_valid%0d", c + 1), rv32, 0);
    end
    hold = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin
        instruction = ins(7,4,0,0,16'd103);
      end else if (c > 1) begin
        instr_valid = 1'b0;
        instruction = '0;
      end
      @(posedge clk); #1;
      if (rv32) got.push_back({rd32, res32});
    end
    exp_cnt += 4;
    chk("hold_npulse", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      chk($sformatf("hold_res%0d", k), got[k],
          {4'(k + 1), 32'(100 + k)});
    end
    chk("hold_cnt", cnt32, exp_cnt);
    chk("illegal_sticky", ill32, 1);

    // reset with an ADDI sitting in X
    instr_valid = 1'b1;
    instruction = ins(7,3,0,0,16'd9);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instruction = '0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_result", res32, 0);
    chk("mrst_rd", rd32, 0);
    chk("mrst_valid", rv32, 0);
    chk("mrst_illegal", ill32, 0);
    chk("mrst_cnt", cnt32, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("mrst_valid_held", rv32, 0);
    reset_n = 1'b1;
    rv_exp[0] = 2'b00;
    rv_exp[1] = 2'b00;
    rv_exp[2] = 2'b01;
    rv_exp[3] = 2'b01;
    for (int c = 0; c < 4; c++) begin
      instr_valid = (c < 2);
      if (c == 0) instruction = ins(3,4,3,0,0);
      else if (c == 1) instruction = ins(1,5,3,3,0);
      else instruction = '0;
      @(posedge clk); #1;
      chk($sformatf("post_valid%0d", c), rv32, rv_exp[c][0]);
      if (rv32) begin
        chk($sformatf("post_res%0d", c), res32, 0);
        chk($sformatf("post_rd%0d", c), rd32, c + 2);
      end
    end
    chk("post_cnt", cnt32, 2);
    chk("post_illegal", ill32, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
